// File: rtl/dram_sched.sv
// rtl/dram_sched.sv - single-outstanding DRAM request scheduler for imem, dmem and the program loader
//
// Serializes imem reads, dmem reads/writes and loader writes onto one DRAM user port. Only one
// transaction is in flight at a time. Each completion is routed back to the requester that owns it.
// dmem beats imem, but a starvation guard forces an imem grant after STARVE_LIMIT consecutive dmem
// grants made while imem was waiting. While ld_en is high only the loader is served.
// Optional macro DRAM_SCHED_STATS_EN adds the stat_igrant/stat_dgrant/stat_starve counters.
//
// Ports:
//   clk, rst_x                     clock, asynchronous active-low reset
//   ld_en, ld_req, ld_addr,        loader mode and write request (written with all byte enables)
//   ld_wdata, ld_done
//   i_req, i_addr, i_rdata,        imem read port
//   i_valid
//   d_req, d_addr, d_wdata, d_we,  dmem port, d_we == 0 means read
//   d_rdata, d_valid, d_written
//   dram_oe, dram_addr,            DRAM command (dram_oe is a one-cycle strobe; dram_we == 0 is a read)
//   dram_wdata, dram_we
//   dram_rdata, dram_valid,        DRAM responses
//   dram_written
//   busy                           high whenever a transaction is in flight
//   stat_igrant, stat_dgrant,      grant counters (DRAM_SCHED_STATS_EN only)
//   stat_starve
module dram_sched #(
    parameter int MEM_SCALE    = 27,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 32
) (
    input  logic                 clk,
    input  logic                 rst_x,
    input  logic                 ld_en,
    input  logic                 ld_req,
    input  logic [MEM_SCALE-1:0] ld_addr,
    input  logic [31:0]          ld_wdata,
    output logic                 ld_done,
    input  logic                 i_req,
    input  logic [MEM_SCALE-1:0] i_addr,
    output logic [31:0]          i_rdata,
    output logic                 i_valid,
    input  logic                 d_req,
    input  logic [MEM_SCALE-1:0] d_addr,
    input  logic [31:0]          d_wdata,
    input  logic [3:0]           d_we,
    output logic [31:0]          d_rdata,
    output logic                 d_valid,
    output logic                 d_written,
    output logic                 dram_oe,
    output logic [MEM_SCALE-1:0] dram_addr,
    output logic [31:0]          dram_wdata,
    output logic [3:0]           dram_we,
    input  logic [31:0]          dram_rdata,
    input  logic                 dram_valid,
    input  logic                 dram_written,
    output logic                 busy
`ifdef DRAM_SCHED_STATS_EN
    ,
    output logic [CNT_W-1:0]     stat_igrant,
    output logic [CNT_W-1:0]     stat_dgrant,
    output logic [CNT_W-1:0]     stat_starve
`endif
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15 || CNT_W < 1) begin : g_param_check
        $error("dram_sched: STARVE_LIMIT must be 1..15 and CNT_W at least 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [1:0] OWN_I = 2'd0;
    localparam logic [1:0] OWN_D = 2'd1;
    localparam logic [1:0] OWN_L = 2'd2;
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    state_t                 state_q, state_d;
    logic [1:0]             owner_q, owner_d;
    logic [3:0]             starve_cnt, starve_d;
    logic                   gnt_i, gnt_d, gnt_l, grant, starve_hit, is_read;

    logic                   dram_oe_d;
    logic [MEM_SCALE-1:0]   dram_addr_d;
    logic [31:0]            dram_wdata_d;
    logic [3:0]             dram_we_d;
    logic [31:0]            i_rdata_d, d_rdata_d;
    logic                   i_valid_d, d_valid_d, d_written_d, ld_done_d, busy_d;

    // The latched byte enables double as the read/write flag of the transaction in flight.
    assign is_read = (dram_we == 4'h0);

    // Arbitration is evaluated every cycle but only acted on in IDLE, so a change of ld_en
    // mid-transaction only takes effect at the next IDLE.
    assign starve_hit = !ld_en && i_req && (starve_cnt == STARVE_MAX);

    always_comb begin
        gnt_i = 1'b0;
        gnt_d = 1'b0;
        gnt_l = 1'b0;
        if (ld_en) begin
            gnt_l = ld_req;
        end else if (starve_hit) begin
            gnt_i = 1'b1;
        end else if (d_req) begin
            gnt_d = 1'b1;
        end else if (i_req) begin
            gnt_i = 1'b1;
        end
    end

    assign grant = (state_q == ST_IDLE) && (gnt_i || gnt_d || gnt_l);

    // State register; every output is a register loaded from its *_d value.
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            state_q    <= ST_IDLE;
            owner_q    <= OWN_I;
            starve_cnt <= 4'd0;
            dram_oe    <= 1'b0;
            dram_addr  <= '0;
            dram_wdata <= 32'd0;
            dram_we    <= 4'h0;
            i_rdata    <= 32'd0;
            d_rdata    <= 32'd0;
            i_valid    <= 1'b0;
            d_valid    <= 1'b0;
            d_written  <= 1'b0;
            ld_done    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            starve_cnt <= starve_d;
            dram_oe    <= dram_oe_d;
            dram_addr  <= dram_addr_d;
            dram_wdata <= dram_wdata_d;
            dram_we    <= dram_we_d;
            i_rdata    <= i_rdata_d;
            d_rdata    <= d_rdata_d;
            i_valid    <= i_valid_d;
            d_valid    <= d_valid_d;
            d_written  <= d_written_d;
            ld_done    <= ld_done_d;
            busy       <= busy_d;
        end
    end

    // Next state. The strobe of the opposite kind is ignored while waiting.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (grant) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (is_read ? dram_valid : dram_written) state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output next-values. The command fields are loaded only on a grant, so they stay stable
    // from ISSUE until RESP exits; read data holds until the next read completion of its port.
    always_comb begin
        owner_d      = owner_q;
        starve_d     = starve_cnt;
        dram_oe_d    = 1'b0;
        dram_addr_d  = dram_addr;
        dram_wdata_d = dram_wdata;
        dram_we_d    = dram_we;
        i_rdata_d    = i_rdata;
        d_rdata_d    = d_rdata;
        i_valid_d    = 1'b0;
        d_valid_d    = 1'b0;
        d_written_d  = 1'b0;
        ld_done_d    = 1'b0;
        busy_d       = (state_d != ST_IDLE);

        if (grant) begin
            dram_oe_d = 1'b1;
            if (gnt_l) begin
                owner_d      = OWN_L;
                dram_addr_d  = ld_addr;
                dram_wdata_d = ld_wdata;
                dram_we_d    = 4'hF;
            end else if (gnt_i) begin
                owner_d      = OWN_I;
                dram_addr_d  = i_addr;
                dram_wdata_d = 32'd0;
                dram_we_d    = 4'h0;
                starve_d     = 4'd0;
            end else begin
                owner_d      = OWN_D;
                dram_addr_d  = d_addr;
                dram_wdata_d = d_wdata;
                dram_we_d    = d_we;
                if (i_req && (starve_cnt != STARVE_MAX)) begin
                    starve_d = starve_cnt + 4'd1;
                end
            end
        end

        if ((state_q == ST_WAIT) && (state_d == ST_RESP)) begin
            case (owner_q)
                OWN_I: begin
                    i_valid_d = 1'b1;
                    i_rdata_d = dram_rdata;
                end
                OWN_D: begin
                    if (is_read) begin
                        d_valid_d = 1'b1;
                        d_rdata_d = dram_rdata;
                    end else begin
                        d_written_d = 1'b1;
                    end
                end
                default: ld_done_d = 1'b1;
            endcase
        end
    end

`ifdef DRAM_SCHED_STATS_EN
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            stat_igrant <= '0;
            stat_dgrant <= '0;
            stat_starve <= '0;
        end else if (grant) begin
            if (gnt_i) stat_igrant <= stat_igrant + CNT_W'(1);
            if (gnt_d) stat_dgrant <= stat_dgrant + CNT_W'(1);
            if (gnt_i && starve_hit) stat_starve <= stat_starve + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_dram_sched.sv
// tb/tb_dram_sched.sv - self-checking bench for dram_sched
module tb_dram_sched;

    localparam int MS    = 27;
    localparam int LIMIT = 4;

    logic          clk = 1'b0;
    logic          rst_x = 1'b1;
    logic          ld_en, ld_req, ld_done;
    logic [MS-1:0] ld_addr, i_addr, d_addr, dram_addr;
    logic [31:0]   ld_wdata, i_rdata, d_wdata, d_rdata, dram_wdata, dram_rdata;
    logic          i_req, i_valid, d_req, d_valid, d_written;
    logic [3:0]    d_we, dram_we;
    logic          dram_oe, dram_valid, dram_written, busy;
`ifdef DRAM_SCHED_STATS_EN
    logic [31:0]   stat_igrant, stat_dgrant, stat_starve;
`endif

    always #5 clk = ~clk;

    dram_sched #(.MEM_SCALE(MS), .STARVE_LIMIT(LIMIT), .CNT_W(32)) dut (
        .clk(clk), .rst_x(rst_x),
        .ld_en(ld_en), .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_done(ld_done),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_valid(i_valid),
        .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_we(d_we),
        .d_rdata(d_rdata), .d_valid(d_valid), .d_written(d_written),
        .dram_oe(dram_oe), .dram_addr(dram_addr), .dram_wdata(dram_wdata), .dram_we(dram_we),
        .dram_rdata(dram_rdata), .dram_valid(dram_valid), .dram_written(dram_written),
        .busy(busy)
`ifdef DRAM_SCHED_STATS_EN
        ,
        .stat_igrant(stat_igrant), .stat_dgrant(stat_dgrant), .stat_starve(stat_starve)
`endif
    );

    // Knobs owned by the stimulus process.
    int resp_lat = 1;
    bit spur_en  = 1'b0;
    int phase    = 0;
    bit done     = 1'b0;
    int timeouts = 0;

    // DRAM responder: answers each command resp_lat cycles after dram_oe, never cancelled by reset.
    int          resp_cnt  = 0;
    bit          resp_rd   = 1'b0;
    logic [31:0] resp_data = 32'h12345678;
    initial begin
        dram_valid   = 1'b0;
        dram_written = 1'b0;
        dram_rdata   = 32'd0;
        forever begin
            @(posedge clk); #1;
            dram_valid   = 1'b0;
            dram_written = 1'b0;
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) begin
                    if (resp_rd) begin
                        dram_valid = 1'b1;
                        dram_rdata = resp_data;
                        resp_data  = resp_data + 32'h01010101;
                    end else begin
                        dram_written = 1'b1;
                    end
                end else if (spur_en && resp_cnt == 1 && !resp_rd) begin
                    dram_valid = 1'b1;
                    dram_rdata = 32'hBAD0BAD0;
                end
            end
            if (dram_oe) begin
                resp_cnt = resp_lat;
                resp_rd  = (dram_we == 4'h0);
            end
        end
    end

    // Transaction-level model: one record for the transaction in flight plus the cycle numbers at
    // which its command strobe and its completion pulse must appear.
    int          cyc = 0, vec_cnt = 0, bad_cnt = 0;
    bit          m_act = 1'b0;
    int          m_owner = 0, m_issue = -1, m_resp = -1, m_starve = 0, win = -1;
    int          m_ig = 0, m_dg = 0, m_fs = 0;
    logic [MS-1:0] e_addr = '0;
    logic [31:0] e_wdata = 32'd0, e_i_rdata = 32'd0, e_d_rdata = 32'd0;
    logic [3:0]  e_we = 4'h0;
    int          glog[$], slog[$], dlog[$];
    int          s3_base = -1, d3_base = -1, ld_rise = -1;
    bit          ld_prev = 1'b0;
    int          exp_ord[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    int          exp_stv[10] = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0};

    function automatic void chk(string nm, logic [63:0] got, logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_x) begin
                m_act = 1'b0; m_issue = -1; m_resp = -1; m_starve = 0;
                m_ig = 0; m_dg = 0; m_fs = 0;
                e_addr = '0; e_wdata = 32'd0; e_we = 4'h0; e_i_rdata = 32'd0; e_d_rdata = 32'd0;
                chk("rst_wdata", 64'(dram_wdata), 64'd0);
                chk("rst_busy", 64'(busy), 64'd0);
            end
            if (phase == 3 && s3_base < 0) begin
                s3_base = glog.size();
                d3_base = dlog.size();
            end

            chk("busy", 64'(busy), 64'(m_act));
            chk("dram_oe", 64'(dram_oe), 64'(m_act && cyc == m_issue));
            chk("dram_addr", 64'(dram_addr), 64'(e_addr));
            chk("dram_we", 64'(dram_we), 64'(e_we));
            if (e_we != 4'h0) chk("dram_wdata", 64'(dram_wdata), 64'(e_wdata));
            chk("i_valid", 64'(i_valid), 64'(m_act && cyc == m_resp && m_owner == 0));
            chk("d_valid", 64'(d_valid), 64'(m_act && cyc == m_resp && m_owner == 1 && e_we == 4'h0));
            chk("d_written", 64'(d_written), 64'(m_act && cyc == m_resp && m_owner == 1 && e_we != 4'h0));
            chk("ld_done", 64'(ld_done), 64'(m_act && cyc == m_resp && m_owner == 2));
            chk("i_rdata", 64'(i_rdata), 64'(e_i_rdata));
            chk("d_rdata", 64'(d_rdata), 64'(e_d_rdata));
`ifdef DRAM_SCHED_STATS_EN
            chk("stat_igrant", 64'(stat_igrant), 64'(m_ig));
            chk("stat_dgrant", 64'(stat_dgrant), 64'(m_dg));
            chk("stat_starve", 64'(stat_starve), 64'(m_fs));
`endif

            // Hand-computed expectations for the directed scenarios.
            if (rst_x && ld_req && !ld_prev) ld_rise = cyc;
            ld_prev = ld_req;
            if (phase == 1 && dram_oe) begin
                chk("ld_cmd_addr", 64'(dram_addr), 64'h100);
                chk("ld_cmd_we", 64'(dram_we), 64'hF);
                chk("ld_cmd_wdata", 64'(dram_wdata), 64'hDEADBEEF);
            end
            if (phase == 1 && ld_done) chk("ld_latency", 64'(cyc - ld_rise), 64'd3);
            if (phase == 2 && i_valid) chk("i_rdata_lit", 64'(i_rdata), 64'h12345678);
            if (phase == 4 && dram_oe) begin
                chk("d_wr_we", 64'(dram_we), 64'h3);
                chk("d_wr_addr", 64'(dram_addr), 64'h8);
            end
            if (phase == 3 && dram_oe) dlog.push_back((dram_addr == 27'h40) ? 0 : 1);
`ifdef DRAM_SCHED_STATS_EN
            if (phase == 3 && dram_oe && (glog.size() - s3_base) == 10) begin
                chk("stat_dgrant_10", 64'(stat_dgrant), 64'd8);
                chk("stat_igrant_10", 64'(stat_igrant), 64'd2);
                chk("stat_starve_10", 64'(stat_starve), 64'd2);
            end
`endif

            // Advance the model with this cycle's inputs.
            if (rst_x) begin
                if (!m_act) begin
                    win = -1;
                    if (ld_en) begin
                        if (ld_req) win = 2;
                    end else if (i_req && m_starve == LIMIT) begin
                        win = 0;
                        m_fs++;
                    end else if (d_req) begin
                        win = 1;
                    end else if (i_req) begin
                        win = 0;
                    end
                    if (win >= 0) begin
                        m_act = 1'b1; m_owner = win; m_issue = cyc + 1; m_resp = -1;
                        case (win)
                            0: begin e_addr = i_addr; e_we = 4'h0; m_starve = 0; m_ig++; end
                            1: begin
                                e_addr = d_addr; e_we = d_we; e_wdata = d_wdata; m_dg++;
                                if (i_req && m_starve < LIMIT) m_starve++;
                            end
                            default: begin e_addr = ld_addr; e_we = 4'hF; e_wdata = ld_wdata; end
                        endcase
                        glog.push_back(win);
                        slog.push_back(m_starve);
                    end
                end else if (m_resp < 0) begin
                    if (cyc > m_issue && ((e_we == 4'h0) ? dram_valid : dram_written)) begin
                        m_resp = cyc + 1;
                        if (m_owner == 0) e_i_rdata = dram_rdata;
                        if (m_owner == 1 && e_we == 4'h0) e_d_rdata = dram_rdata;
                    end
                end else if (cyc == m_resp) begin
                    m_act = 1'b0;
                end
            end

            if (done || cyc > 4000) begin
                chk("watchdog", 64'(cyc > 4000), 64'd0);
                chk("stim_timeouts", 64'(timeouts), 64'd0);
                chk("s3_grants", 64'((dlog.size() - d3_base) >= 10 && (glog.size() - s3_base) >= 10), 64'd1);
                if ((dlog.size() - d3_base) >= 10 && (glog.size() - s3_base) >= 10) begin
                    for (int k = 0; k < 10; k++) begin
                        chk($sformatf("dut_order%0d", k), 64'(dlog[d3_base + k]), 64'(exp_ord[k]));
                        chk($sformatf("model_order%0d", k), 64'(glog[s3_base + k]), 64'(exp_ord[k]));
                        chk($sformatf("model_starve%0d", k), 64'(slog[s3_base + k]), 64'(exp_stv[k]));
                    end
                end
                $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, bad_cnt);
                $finish;
            end
        end
    end

    // which: 0 i_valid, 1 d_valid, 2 d_written, 3 ld_done. Returns just after the following
    // rising edge, which is when a requester drops or renews its request.
    task automatic wait_pulse(input int which, input int budget);
        bit hit = 1'b0;
        int k = 0;
        while (!hit && k < budget) begin
            @(negedge clk);
            case (which)
                0: hit = i_valid;
                1: hit = d_valid;
                2: hit = d_written;
                default: hit = ld_done;
            endcase
            k++;
        end
        if (!hit) timeouts++;
        @(posedge clk); #1;
    endtask

    initial begin
        ld_en = 1'b1; ld_req = 1'b0; ld_addr = '0; ld_wdata = 32'd0;
        i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_addr = '0; d_wdata = 32'd0; d_we = 4'h0;
        #1 rst_x = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_x = 1'b1;
        @(posedge clk); #1;

        // Loader write while imem is also requesting; then imem read with a slow DRAM.
        phase = 1; resp_lat = 1;
        ld_addr = 27'h100; ld_wdata = 32'hDEADBEEF; ld_req = 1'b1;
        i_addr = 27'h40; i_req = 1'b1;
        wait_pulse(3, 20);
        ld_req = 1'b0; ld_en = 1'b0; phase = 2; resp_lat = 5;
        wait_pulse(0, 30);
        i_req = 1'b0;
        repeat (2) @(posedge clk); #1;

        // dmem partial write with a spurious read strobe during the wait.
        phase = 4; resp_lat = 3; spur_en = 1'b1;
        d_addr = 27'h8; d_wdata = 32'hCAFEF00D; d_we = 4'h3; d_req = 1'b1;
        wait_pulse(2, 30);
        d_req = 1'b0; spur_en = 1'b0;
        repeat (2) @(posedge clk); #1;

        // Reset during the wait of a dmem read; the DRAM strobe then arrives after release.
        phase = 5; resp_lat = 6;
        d_addr = 27'h20; d_we = 4'h0; d_req = 1'b1;
        repeat (3) @(posedge clk); #1;
        rst_x = 1'b0; d_req = 1'b0;
        repeat (2) @(posedge clk); #1;
        rst_x = 1'b1;
        repeat (8) @(posedge clk); #1;

        // imem and dmem both held; dmem re-requests immediately after each completion.
        phase = 3; resp_lat = 1;
        i_addr = 27'h40; d_addr = 27'h80; d_we = 4'h0; i_req = 1'b1; d_req = 1'b1;
        wait_pulse(0, 200);
        wait_pulse(0, 200);
        i_req = 1'b0;
        wait_pulse(1, 50);
        d_req = 1'b0;
        repeat (4) @(posedge clk); #1;
        done = 1'b1;
    end

endmodule
